hazard_ctrl: RTL

- Stall/flush controller for the 5-stage pipeline.
- Tracks the destination register and remaining result latency (Tnew) of the instructions in the E and M stages.
- Compares them against the source-use deadlines (Tuse) of the instruction in D and tracks the multi-cycle mult/div unit.
- Drives the F/D register stall, the PC enable and the D/E flush (bubble insertion).

---
 rtl/hazard_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: E/M destination scoreboard vs D source deadlines plus mult/div busy tracking.
// stall/flush_E are combinational from the D inputs; optional counters behind HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  a3_D,
  input  logic [1:0]  tnew_D,
  input  logic        md_start_D,
  input  logic        md_div_D,
  input  logic        md_use_D,
  output logic        stall,
  output logic        flush_E,
  output logic        md_busy,
  output logic [4:0]  a3_E,
  output logic [4:0]  a3_M
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt
`endif
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  logic [1:0]       tnew_E;
  logic [1:0]       tnew_M;
  logic             start_E;
  logic             div_E;
  logic [CNT_W-1:0] md_cnt;
  logic             rs_haz;
  logic             rt_haz;
  logic             md_haz;

  // A source conflicts only if the producer's result arrives after the consumer needs it.
  always_comb begin
    rs_haz = (rs_D != 5'd0) && (tuse_rs_D != 2'd3) &&
             (((rs_D == a3_E) && (tnew_E > tuse_rs_D)) ||
              ((rs_D == a3_M) && (tnew_M > tuse_rs_D)));
    rt_haz = (rt_D != 5'd0) && (tuse_rt_D != 2'd3) &&
             (((rt_D == a3_E) && (tnew_E > tuse_rt_D)) ||
              ((rt_D == a3_M) && (tnew_M > tuse_rt_D)));
  end

  assign md_busy = start_E | (md_cnt != '0);
  assign md_haz  = md_use_D & md_busy;
  assign stall   = rs_haz | rt_haz | md_haz;
  assign flush_E = stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_E    <= 5'd0;
      tnew_E  <= 2'd0;
      start_E <= 1'b0;
      div_E   <= 1'b0;
      a3_M    <= 5'd0;
      tnew_M  <= 2'd0;
      md_cnt  <= '0;
    end else begin
      a3_M   <= a3_E;
      tnew_M <= (tnew_E == 2'd0) ? 2'd0 : tnew_E - 2'd1;
      if (stall) begin
        a3_E    <= 5'd0;
        tnew_E  <= 2'd0;
        start_E <= 1'b0;
      end else begin
        a3_E    <= a3_D;
        tnew_E  <= tnew_D;
        start_E <= md_start_D;
        div_E   <= md_div_D;
      end
      // A new start always reloads, even over a running operation.
      if (start_E)
        md_cnt <= div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= 32'd0;
      md_stall_cnt <= 32'd0;
    end else begin
      if (stall)
        stall_cnt <= stall_cnt + 32'd1;
      if (md_haz && !rs_haz && !rt_haz)
        md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
